// File: rtl/pq_heap_ctrl.sv
// rtl/pq_heap_ctrl.sv - binary-heap priority-queue controller driving a 1-cycle-latency BRAM
//
// Purpose: keeps a 1-based binary heap of {key,data} words in an external BRAM.
//   It sequences sift-up for enqueue and sift-down for dequeue/replace.
//   It handles one request at a time and accepts a new request only while ready=1.
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   enq, deq, din          request strobes and {key,data} to insert (sampled when ready=1)
//   ready                  idle, request accepted this cycle
//   dout_valid, dout       one-cycle pulse carrying the dequeued root
//   count, full, empty     occupancy (updated at accept)
//   err                    one-cycle pulse: request dropped (enq on full / deq on empty)
//   mem_re/raddr/rdata     BRAM read port, rdata valid the cycle after mem_re
//   mem_we/waddr/wdata     BRAM write port
module pq_heap_ctrl #(
  parameter int KEY_W    = 16,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int MAX_HEAP = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq,
  input  logic                      deq,
  input  logic [KEY_W+DATA_W-1:0]   din,
  output logic                      ready,
  output logic                      dout_valid,
  output logic [KEY_W+DATA_W-1:0]   dout,
  output logic [ADDR_W-1:0]         count,
  output logic                      full,
  output logic                      empty,
  output logic                      err,
  output logic                      mem_re,
  output logic [ADDR_W-1:0]         mem_raddr,
  input  logic [KEY_W+DATA_W-1:0]   mem_rdata,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_waddr,
  output logic [KEY_W+DATA_W-1:0]   mem_wdata
);

  localparam int W = KEY_W + DATA_W;
  localparam logic [ADDR_W-1:0] CAP = '1;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_FIN, S_E_RD, S_E_CMP, S_E_TOP,
    S_R_RD, S_R_OUT, S_R_LD, S_R_GET,
    S_SIFT, S_S_A, S_S_B, S_S_C
  } state_t;

  state_t            state;
  logic              is_rep;   // current read-root op is a replace (item already holds din)
  logic [W-1:0]      item;     // element travelling through the heap
  logic [W-1:0]      lval;     // left child captured while the right child is read
  logic [ADDR_W-1:0] hole;
  logic [ADDR_W-1:0] last;

  // Strictly better in the configured order; equal keys are never better,
  // so ties never cause a move.
  function automatic logic better(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [KEY_W-1:0] ka;
    logic [KEY_W-1:0] kb;
    ka = a[W-1 -: KEY_W];
    kb = b[W-1 -: KEY_W];
    if (MAX_HEAP != 0) return ka > kb;
    else               return ka < kb;
  endfunction

  logic [ADDR_W-1:0] next_cnt;
  logic [ADDR_W-1:0] parent;
  logic [ADDR_W:0]   l_idx;    // one extra bit so 2*hole never wraps
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   last_ext;
  logic              r_in;
  logic [W-1:0]      child_w;
  logic [ADDR_W-1:0] child_i;

  assign next_cnt = count + ONE;
  assign parent   = hole >> 1;
  assign l_idx    = {hole, 1'b0};
  assign r_idx    = l_idx + 1'b1;
  assign last_ext = {1'b0, last};
  assign r_in     = (r_idx <= last_ext);
  assign full     = (count == CAP);
  assign empty    = (count == '0);

  // Child selection: in S_S_B only the left child exists (rdata = L);
  // in S_S_C rdata = R and the left child was captured in lval. Tie keeps L.
  always_comb begin
    child_w = lval;
    child_i = l_idx[ADDR_W-1:0];
    if (state == S_S_B) begin
      child_w = mem_rdata;
    end else if (better(mem_rdata, lval)) begin
      child_w = mem_rdata;
      child_i = r_idx[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      is_rep     <= 1'b0;
      item       <= '0;
      lval       <= '0;
      hole       <= '0;
      last       <= '0;
      count      <= '0;
      ready      <= 1'b1;
      dout_valid <= 1'b0;
      dout       <= '0;
      err        <= 1'b0;
      mem_re     <= 1'b0;
      mem_raddr  <= '0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enq && deq && !empty) begin
            // Replace: pop root, then sift the new item down from the root.
            item      <= din;
            is_rep    <= 1'b1;
            ready     <= 1'b0;
            mem_re    <= 1'b1;
            mem_raddr <= ONE;
            state     <= S_R_RD;
          end else if (enq && !full) begin
            // Plain insert; an accompanying deq can only reach here on empty and is dropped.
            err   <= deq;
            item  <= din;
            count <= next_cnt;
            ready <= 1'b0;
            if (empty) begin
              hole      <= ONE;
              mem_we    <= 1'b1;
              mem_waddr <= ONE;
              mem_wdata <= din;
              state     <= S_WR_FIN;
            end else begin
              hole      <= next_cnt;
              mem_re    <= 1'b1;
              mem_raddr <= next_cnt >> 1;
              state     <= S_E_RD;
            end
          end else if (deq && !enq && !empty) begin
            is_rep    <= 1'b0;
            count     <= count - ONE;
            ready     <= 1'b0;
            mem_re    <= 1'b1;
            mem_raddr <= ONE;
            state     <= S_R_RD;
          end else if (enq || deq) begin
            err <= 1'b1;
          end
        end

        S_WR_FIN: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end

        S_E_RD: state <= S_E_CMP;

        S_E_CMP: begin
          mem_we <= 1'b1;
          if (better(item, mem_rdata)) begin
            // Parent moves down into the hole; the hole climbs.
            mem_waddr <= hole;
            mem_wdata <= mem_rdata;
            hole      <= parent;
            if (parent == ONE) begin
              state <= S_E_TOP;
            end else begin
              mem_re    <= 1'b1;
              mem_raddr <= parent >> 1;
              state     <= S_E_RD;
            end
          end else begin
            mem_waddr <= hole;
            mem_wdata <= item;
            state     <= S_WR_FIN;
          end
        end

        S_E_TOP: begin
          mem_we    <= 1'b1;
          mem_waddr <= hole;
          mem_wdata <= item;
          state     <= S_WR_FIN;
        end

        S_R_RD: state <= S_R_OUT;

        S_R_OUT: begin
          dout       <= mem_rdata;
          dout_valid <= 1'b1;
          if (is_rep) begin
            hole  <= ONE;
            last  <= count;
            state <= S_SIFT;
          end else if (count == '0) begin
            ready <= 1'b1;
            state <= S_IDLE;
          end else begin
            // count was already decremented; the old last slot is count+1.
            mem_re    <= 1'b1;
            mem_raddr <= next_cnt;
            state     <= S_R_LD;
          end
        end

        S_R_LD: state <= S_R_GET;

        S_R_GET: begin
          item  <= mem_rdata;
          hole  <= ONE;
          last  <= count;
          state <= S_SIFT;
        end

        S_SIFT: begin
          if (l_idx > last_ext) begin
            mem_we    <= 1'b1;
            mem_waddr <= hole;
            mem_wdata <= item;
            state     <= S_WR_FIN;
          end else begin
            mem_re    <= 1'b1;
            mem_raddr <= l_idx[ADDR_W-1:0];
            state     <= S_S_A;
          end
        end

        S_S_A: begin
          if (r_in) begin
            mem_re    <= 1'b1;
            mem_raddr <= r_idx[ADDR_W-1:0];
          end
          state <= S_S_B;
        end

        S_S_B, S_S_C: begin
          if (state == S_S_B) lval <= mem_rdata;
          if (state == S_S_B && r_in) begin
            state <= S_S_C;
          end else begin
            mem_we    <= 1'b1;
            mem_waddr <= hole;
            if (better(child_w, item)) begin
              mem_wdata <= child_w;
              hole      <= child_i;
              state     <= S_SIFT;
            end else begin
              mem_wdata <= item;
              state     <= S_WR_FIN;
            end
          end
        end

        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pq_heap_ctrl.sv
// tb/tb_pq_heap_ctrl.sv - self-checking bench for pq_heap_ctrl (min and max instances)
module tb_pq_heap_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        enq [2];
  logic        deq [2];
  logic [31:0] din [2];
  logic        ready [2];
  logic        dout_valid [2];
  logic [31:0] dout [2];
  logic [2:0]  count [2];
  logic        full [2];
  logic        empty [2];
  logic        err [2];
  logic        mem_re [2];
  logic [2:0]  mem_raddr [2];
  logic [31:0] mem_rdata [2];
  logic        mem_we [2];
  logic [2:0]  mem_waddr [2];
  logic [31:0] mem_wdata [2];

  for (genvar g = 0; g < 2; g++) begin : gi
    logic [31:0] mem [8];
    pq_heap_ctrl #(.KEY_W(16), .DATA_W(16), .ADDR_W(3), .MAX_HEAP(g)) dut (
      .clk(clk), .rst(rst), .enq(enq[g]), .deq(deq[g]), .din(din[g]),
      .ready(ready[g]), .dout_valid(dout_valid[g]), .dout(dout[g]),
      .count(count[g]), .full(full[g]), .empty(empty[g]), .err(err[g]),
      .mem_re(mem_re[g]), .mem_raddr(mem_raddr[g]), .mem_rdata(mem_rdata[g]),
      .mem_we(mem_we[g]), .mem_waddr(mem_waddr[g]), .mem_wdata(mem_wdata[g])
    );
    always @(posedge clk) begin
      if (mem_we[g]) mem[mem_waddr[g]] <= mem_wdata[g];
      if (mem_re[g]) mem_rdata[g] <= mem[mem_raddr[g]];
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model: an unordered bag of keys per instance; g=0 pops the
  // smallest, g=1 the largest. Payload is a fixed function of the key.
  int mq   [2][$];
  int expq [2][$];
  int got  [2][$];
  bit err_due [2];
  int we_cnt [2];

  function automatic logic [15:0] dfun(input int k);
    return 16'(k * 37 + 11);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_best(input int g, output int k);
    int bi = 0;
    for (int i = 1; i < mq[g].size(); i++)
      if ((g == 0) ? (mq[g][i] < mq[g][bi]) : (mq[g][i] > mq[g][bi])) bi = i;
    k = mq[g][bi];
    mq[g].delete(bi);
  endtask

  task automatic wait_ready(input int g, input string nm);
    int n = 0;
    while (!ready[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready[g]) begin
      errors++;
      checks++;
      $display("FAIL %s[%0d]: ready got 0 expected 1 within 200 cycles", nm, g);
    end
  endtask

  // Called at a negedge; returns at a negedge with the controller idle again.
  task automatic op(input int g, input bit e, input bit d, input int key);
    int k;
    bit emp;
    wait_ready(g, "op_start");
    if (!ready[g]) return;
    emp = (mq[g].size() == 0);
    enq[g] = e;
    deq[g] = d;
    din[g] = {key[15:0], dfun(key)};
    if (e && d) begin
      if (emp) begin
        mq[g].push_back(key);
        err_due[g] = 1'b1;
      end else begin
        pop_best(g, k);
        expq[g].push_back(k);
        mq[g].push_back(key);
      end
    end else if (e) begin
      if (mq[g].size() == 7) err_due[g] = 1'b1;
      else mq[g].push_back(key);
    end else if (d) begin
      if (emp) err_due[g] = 1'b1;
      else begin
        pop_best(g, k);
        expq[g].push_back(k);
      end
    end
    @(negedge clk);
    enq[g] = 1'b0;
    deq[g] = 1'b0;
    wait_ready(g, "op_end");
  endtask

  task automatic chk_got(input int g, input int n, input int ex[4]);
    chk($sformatf("got_len[%0d]", g), 64'(got[g].size()), 64'(n));
    for (int i = 0; i < n && i < got[g].size(); i++)
      chk($sformatf("got_key[%0d][%0d]", g, i), 64'(got[g][i]), 64'(ex[i]));
  endtask

  // Per-cycle compare against the model, just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("count[%0d]", g), 64'(count[g]), 64'(mq[g].size()));
        chk($sformatf("empty[%0d]", g), 64'(empty[g]), 64'(mq[g].size() == 0));
        chk($sformatf("full[%0d]", g), 64'(full[g]), 64'(mq[g].size() == 7));
        chk($sformatf("err[%0d]", g), 64'(err[g]), 64'(err_due[g]));
        err_due[g] = 1'b0;
        if (mem_we[g]) we_cnt[g]++;
        if (dout_valid[g]) begin
          if (expq[g].size() == 0) begin
            chk($sformatf("dout_valid_unexpected[%0d]", g), 64'(dout_valid[g]), 64'(0));
          end else begin
            int k;
            k = expq[g].pop_front();
            chk($sformatf("dout_key[%0d]", g), 64'(dout[g][31:16]), 64'(k));
            chk($sformatf("dout_data[%0d]", g), 64'(dout[g][15:0]), 64'(dfun(k)));
            got[g].push_back(int'(dout[g][31:16]));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex[4];
    int n;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      enq[g] = 1'b0;
      deq[g] = 1'b0;
      din[g] = '0;
      err_due[g] = 1'b0;
      we_cnt[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ready", 64'(ready[g]), 64'(1));
      chk("rst_count", 64'(count[g]), 64'(0));
      chk("rst_empty", 64'(empty[g]), 64'(1));
      chk("rst_full", 64'(full[g]), 64'(0));
      chk("rst_dout_valid", 64'(dout_valid[g]), 64'(0));
      chk("rst_mem_re", 64'(mem_re[g]), 64'(0));
      chk("rst_mem_we", 64'(mem_we[g]), 64'(0));
      chk("rst_dout", 64'(dout[g]), 64'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    // Min heap: enq 5,3,8,1 then drain.
    op(0, 1, 0, 5); op(0, 1, 0, 3); op(0, 1, 0, 8); op(0, 1, 0, 1);
    chk("min_count4", 64'(count[0]), 64'(4));
    chk("min_root_key", 64'(gi[0].mem[1][31:16]), 64'(1));
    got[0].delete();
    repeat (4) op(0, 0, 1, 0);
    ex = '{1, 3, 5, 8};
    chk_got(0, 4, ex);
    chk("min_empty_after", 64'(empty[0]), 64'(1));

    // Fill to capacity, overflow, drain, underflow.
    for (int k = 1; k <= 7; k++) op(0, 1, 0, (k * 13) % 17);
    op(0, 1, 0, 99);
    chk("full_count7", 64'(count[0]), 64'(7));
    chk("full_flag", 64'(full[0]), 64'(1));
    repeat (7) op(0, 0, 1, 0);
    op(0, 0, 1, 0);
    chk("under_count0", 64'(count[0]), 64'(0));

    // Replace on {2,4,6} with key 9.
    op(0, 1, 0, 6); op(0, 1, 0, 2); op(0, 1, 0, 4);
    got[0].delete();
    op(0, 1, 1, 9);
    chk("rep_count3", 64'(count[0]), 64'(3));
    repeat (3) op(0, 0, 1, 0);
    ex = '{2, 4, 6, 9};
    chk_got(0, 4, ex);

    // enq+deq on empty: plain insert with err pulse.
    op(0, 1, 1, 12);
    chk("ed_empty_count", 64'(count[0]), 64'(1));
    op(0, 0, 1, 0);

    // Max heap with equal keys.
    op(1, 1, 0, 5);
    we_cnt[1] = 0;
    op(1, 1, 0, 5);
    chk("max_tie_writes", 64'(we_cnt[1]), 64'(1));
    we_cnt[1] = 0;
    op(1, 1, 0, 7);
    chk("max_climb_writes", 64'(we_cnt[1]), 64'(2));
    got[1].delete();
    repeat (3) op(1, 0, 1, 0);
    ex = '{7, 5, 5, 0};
    chk_got(1, 3, ex);

    // Reset in the middle of a sift-down.
    op(0, 1, 0, 9); op(0, 1, 0, 2); op(0, 1, 0, 7); op(0, 1, 0, 4); op(0, 1, 0, 6);
    wait_ready(0, "rst_test");
    begin
      int k;
      deq[0] = 1'b1;
      pop_best(0, k);
      expq[0].push_back(k);
    end
    @(negedge clk);
    deq[0] = 1'b0;
    n = 0;
    while (!dout_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_dout_seen", 64'(dout_valid[0]), 64'(1));
    repeat (3) @(negedge clk);
    chk("rst_test_busy", 64'(ready[0]), 64'(0));
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      mq[g].delete();
      expq[g].delete();
      err_due[g] = 1'b0;
    end
    @(negedge clk);
    chk("abort_ready", 64'(ready[0]), 64'(1));
    chk("abort_count", 64'(count[0]), 64'(0));
    chk("abort_empty", 64'(empty[0]), 64'(1));
    chk("abort_mem_we", 64'(mem_we[0]), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    op(0, 1, 0, 4);
    got[0].delete();
    op(0, 0, 1, 0);
    ex = '{4, 0, 0, 0};
    chk_got(0, 1, ex);

    repeat (2) @(negedge clk);
    chk("pending_dout0", 64'(expq[0].size()), 64'(0));
    chk("pending_dout1", 64'(expq[1].size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
